// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the count-register width helper.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Wide enough to hold WIDTH-1 with one bit of headroom.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Single-bit full subtractor cell: x - y - bin -> difference d, borrow bout.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = count_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, result_q, diff_q;
    logic [CW-1:0]    count_q;
    logic             borrow_q, borrow_out_q;
    logic             d_bit, bo_bit, last_bit;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;
`endif

    full_subtractor_bit u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bo_bit)
    );

    assign last_bit = (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q         <= '0;
            sb_q         <= '0;
            result_q     <= '0;
            diff_q       <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    result_q <= {d_bit, result_q[WIDTH-1:1]};
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    borrow_q <= bo_bit;
                    count_q  <= count_q + CW'(1);
                    // Publish on the final bit so outputs only move as DONE begins.
                    if (last_bit) begin
                        diff_q       <= {d_bit, result_q[WIDTH-1:1]};
                        borrow_out_q <= bo_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf_q        <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands against an
// arithmetic reference, plus an exhaustive check of the full_subtractor_bit cell.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    logic fx, fy, fbin, fd, fbout;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] prev_diff = '0;
    logic         prev_borrow = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    full_subtractor_bit u_fs (
        .x    (fx),
        .y    (fy),
        .bin  (fbin),
        .d    (fd),
        .bout (fbout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; inject_at >= 0 pulses a spurious start during that SHIFT cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int inject_at);
        int exp_full;
        logic [W-1:0] exp_diff;
        logic exp_borrow;
        int dones;
        exp_full   = int'(av) - int'(bv);
        exp_diff   = W'(exp_full);
        exp_borrow = (av < bv);
        dones      = 0;

        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check("busy_in_shift", 32'(busy), 32'd1);
            check("done_in_shift", 32'(done), 32'd0);
            check("diff_stable_shift", 32'(diff), 32'(prev_diff));
            check("borrow_stable_shift", 32'(borrow_out), 32'(prev_borrow));
            start = (i == inject_at);
            if (i == inject_at) begin
                a = 8'h99;
                b = 8'h11;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("diff", 32'(diff), 32'(exp_diff));
        check("borrow_out", 32'(borrow_out), 32'(exp_borrow));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf", 32'(ovf),
              32'((av[W-1] != bv[W-1]) && (exp_diff[W-1] != av[W-1])));
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            check("busy_idle", 32'(busy), 32'd0);
        end
        check("no_extra_done", 32'(dones), 32'd0);
        check("diff_held", 32'(diff), 32'(exp_diff));
        prev_diff   = exp_diff;
        prev_borrow = exp_borrow;
    endtask

    initial begin
        // Full-subtractor cell: x - y - bin == d - 2*bout.
        for (int i = 0; i < 8; i++) begin
            int v;
            {fx, fy, fbin} = 3'(i);
            #1;
            v = int'(fx) - int'(fy) - int'(fbin);
            check("cell_d", 32'(fd), 32'(v & 1));
            check("cell_bout", 32'(fbout), 32'(v < 0));
        end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif

        run_op(8'h5A, 8'h23, -1);
        run_op(8'h10, 8'h20, -1);
        run_op(8'h00, 8'h00, -1);
        run_op(8'h00, 8'h01, -1);
        run_op(8'hFF, 8'hFF, -1);
        run_op(8'h40, 8'h01, 2);
        run_op(8'h40, 8'h01, -1);

        // Abort in the 4th SHIFT cycle.
        @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        prev_diff   = '0;
        prev_borrow = 1'b0;
        run_op(8'h08, 8'h03, -1);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        run_op(8'h80, 8'h01, -1);
        run_op(8'h7F, 8'hFF, -1);
        run_op(8'h05, 8'h03, -1);
`endif

        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
